// File: rtl/ar_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : ar_arbiter_if
// Description : AXI read-address bundle for a 2-master / 3-slave arbiter.
//               'master' is the surrounding system's view, 'slave' is the
//               arbiter's view.
// Revision    : 1.0 - initial release
// ============================================================================
interface ar_arbiter_if;
    logic [3:0]  ARID_M0, ARID_M1;
    logic [31:0] ARADDR_M0, ARADDR_M1;
    logic [3:0]  ARLEN_M0, ARLEN_M1;
    logic [2:0]  ARSIZE_M0, ARSIZE_M1;
    logic [1:0]  ARBURST_M0, ARBURST_M1;
    logic        ARVALID_M0, ARVALID_M1;
    logic        ARREADY_M0, ARREADY_M1;
    logic [7:0]  ARID_S;
    logic [31:0] ARADDR_S;
    logic [3:0]  ARLEN_S;
    logic [2:0]  ARSIZE_S;
    logic [1:0]  ARBURST_S;
    logic        ARVALID_S0, ARVALID_S1, ARVALID_SDEFAULT;
    logic        ARREADY_S0, ARREADY_S1, ARREADY_SDEFAULT;
    logic        RVALID_S0, RREADY_S0, RLAST_S0;
    logic        RVALID_S1, RREADY_S1, RLAST_S1;
    logic        RVALID_SDEFAULT, RREADY_SDEFAULT, RLAST_SDEFAULT;

    modport master (
        output ARID_M0, ARID_M1, ARADDR_M0, ARADDR_M1, ARLEN_M0, ARLEN_M1,
               ARSIZE_M0, ARSIZE_M1, ARBURST_M0, ARBURST_M1,
               ARVALID_M0, ARVALID_M1,
               ARREADY_S0, ARREADY_S1, ARREADY_SDEFAULT,
               RVALID_S0, RREADY_S0, RLAST_S0,
               RVALID_S1, RREADY_S1, RLAST_S1,
               RVALID_SDEFAULT, RREADY_SDEFAULT, RLAST_SDEFAULT,
        input  ARREADY_M0, ARREADY_M1, ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S,
               ARBURST_S, ARVALID_S0, ARVALID_S1, ARVALID_SDEFAULT
    );

    modport slave (
        input  ARID_M0, ARID_M1, ARADDR_M0, ARADDR_M1, ARLEN_M0, ARLEN_M1,
               ARSIZE_M0, ARSIZE_M1, ARBURST_M0, ARBURST_M1,
               ARVALID_M0, ARVALID_M1,
               ARREADY_S0, ARREADY_S1, ARREADY_SDEFAULT,
               RVALID_S0, RREADY_S0, RLAST_S0,
               RVALID_S1, RREADY_S1, RLAST_S1,
               RVALID_SDEFAULT, RREADY_SDEFAULT, RLAST_SDEFAULT,
        output ARREADY_M0, ARREADY_M1, ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S,
               ARBURST_S, ARVALID_S0, ARVALID_S1, ARVALID_SDEFAULT
    );
endinterface
`default_nettype wire

// File: rtl/ar_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ar_arbiter
// Description : Round-robin AR arbiter, 2 masters to 3 slaves, one read
//               outstanding; tracks R beats and flags burst-length mismatch.
// Revision    : 1.0 - initial release
// ============================================================================
module ar_arbiter #(
    parameter logic [31:0] S0_BASE = 32'h0000_0000,
    parameter logic [31:0] S1_BASE = 32'h0001_0000
) (
    input  logic        clk,
    input  logic        rst,
    ar_arbiter_if.slave bus,
    output logic        busy,
    output logic [1:0]  grant,
    output logic        beat_err
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_id, r_len;
    logic [31:0] r_addr;
    logic [2:0]  r_size;
    logic [1:0]  r_burst, r_grant;
    logic        r_last_m1;
    logic [4:0]  r_cnt;
    logic        r_over, r_beat_err;

    logic w_hit0, w_hit1, w_sel0, w_sel1, w_seld;
    logic w_tgt_ready, w_rvalid, w_rready, w_rlast, w_rhs;
    logic w_pick_m1, w_acc0, w_acc1, w_err_nxt, w_cnt_inc, w_set_over;

    // Decode from the registered address; it stays valid through DATA too.
    assign w_hit0 = (r_addr - S0_BASE) < 32'h0001_0000;
    assign w_hit1 = (r_addr - S1_BASE) < 32'h0001_0000;
    assign w_sel0 = w_hit0;
    assign w_sel1 = ~w_hit0 & w_hit1;
    assign w_seld = ~w_hit0 & ~w_hit1;

    assign w_tgt_ready = (w_sel0 & bus.ARREADY_S0) | (w_sel1 & bus.ARREADY_S1) |
                         (w_seld & bus.ARREADY_SDEFAULT);
    assign w_rvalid = (w_sel0 & bus.RVALID_S0) | (w_sel1 & bus.RVALID_S1) |
                      (w_seld & bus.RVALID_SDEFAULT);
    assign w_rready = (w_sel0 & bus.RREADY_S0) | (w_sel1 & bus.RREADY_S1) |
                      (w_seld & bus.RREADY_SDEFAULT);
    assign w_rlast  = (w_sel0 & bus.RLAST_S0) | (w_sel1 & bus.RLAST_S1) |
                      (w_seld & bus.RLAST_SDEFAULT);
    assign w_rhs    = w_rvalid & w_rready;

    // M1 wins when alone, or on a tie when M0 was the previous owner.
    assign w_pick_m1 = bus.ARVALID_M1 & (~bus.ARVALID_M0 | ~r_last_m1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_acc0      = 1'b0;
        w_acc1      = 1'b0;
        w_err_nxt   = 1'b0;
        w_cnt_inc   = 1'b0;
        w_set_over  = 1'b0;
        case (r_state)
            IDLE: begin
                if (!rst && (bus.ARVALID_M0 || bus.ARVALID_M1)) begin
                    w_acc0      = ~w_pick_m1;
                    w_acc1      = w_pick_m1;
                    w_state_nxt = ADDR;
                end
            end
            ADDR: begin
                if (w_tgt_ready) w_state_nxt = DATA;
            end
            DATA: begin
                if (w_rhs) begin
                    if (w_rlast) begin
                        w_state_nxt = IDLE;
                        w_err_nxt   = ~r_over & (r_cnt != {1'b0, r_len});
                    end else begin
                        w_cnt_inc = 1'b1;
                        // An overrun is reported once; the later RLAST stays silent.
                        if (!r_over && r_cnt == {1'b0, r_len}) begin
                            w_err_nxt  = 1'b1;
                            w_set_over = 1'b1;
                        end
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_id       <= 4'h0;
            r_addr     <= 32'h0;
            r_len      <= 4'h0;
            r_size     <= 3'h0;
            r_burst    <= 2'h0;
            r_grant    <= 2'b00;
            r_last_m1  <= 1'b1;
            r_cnt      <= 5'h0;
            r_over     <= 1'b0;
            r_beat_err <= 1'b0;
        end else begin
            r_beat_err <= w_err_nxt;
            if (w_acc0 || w_acc1) begin
                r_id      <= w_acc1 ? bus.ARID_M1    : bus.ARID_M0;
                r_addr    <= w_acc1 ? bus.ARADDR_M1  : bus.ARADDR_M0;
                r_len     <= w_acc1 ? bus.ARLEN_M1   : bus.ARLEN_M0;
                r_size    <= w_acc1 ? bus.ARSIZE_M1  : bus.ARSIZE_M0;
                r_burst   <= w_acc1 ? bus.ARBURST_M1 : bus.ARBURST_M0;
                r_grant   <= {w_acc1, w_acc0};
                r_last_m1 <= w_acc1;
            end
            if (r_state == DATA && w_state_nxt == IDLE) r_grant <= 2'b00;
            if (r_state == ADDR && w_state_nxt == DATA) begin
                r_cnt  <= 5'h0;
                r_over <= 1'b0;
            end else begin
                if (w_cnt_inc && r_cnt != 5'h1F) r_cnt <= r_cnt + 5'd1;
                if (w_set_over) r_over <= 1'b1;
            end
        end
    end

    assign bus.ARREADY_M0       = w_acc0;
    assign bus.ARREADY_M1       = w_acc1;
    assign bus.ARVALID_S0       = (r_state == ADDR) & w_sel0;
    assign bus.ARVALID_S1       = (r_state == ADDR) & w_sel1;
    assign bus.ARVALID_SDEFAULT = (r_state == ADDR) & w_seld;
    assign bus.ARID_S           = {2'b00, r_grant, r_id};
    assign bus.ARADDR_S         = r_addr;
    assign bus.ARLEN_S          = r_len;
    assign bus.ARSIZE_S         = r_size;
    assign bus.ARBURST_S        = r_burst;

    assign busy     = (r_state != IDLE);
    assign grant    = r_grant;
    assign beat_err = r_beat_err;
endmodule
`default_nettype wire

// File: doc/ar_arbiter.md
AR_ARBITER -- requirements
Module: ar_arbiter

Parameters
REQ-001 The block SHALL have parameter S0_BASE, default 32'h0000_0000, meaning base address of slave 0 (64 KiB window).
REQ-002 The block SHALL have parameter S1_BASE, default 32'h0001_0000, meaning base address of slave 1 (64 KiB window).

Interface
REQ-003 The block SHALL have ports, as "name  direction  width  meaning":
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ARID_M0/ARID_M1  in  4  master read IDs.
- ARADDR_M0/ARADDR_M1  in  32  read addresses.
- ARLEN_M0/ARLEN_M1  in  4  burst length minus one.
- ARSIZE_M0/ARSIZE_M1  in  3  beat size.
- ARBURST_M0/ARBURST_M1  in  2  burst type.
- ARVALID_M0/ARVALID_M1  in  1  master request valid.
- ARREADY_M0/ARREADY_M1  out  1  master request accepted.
- ARID_S  out  8  slave ID; see REQ-008.
- ARADDR_S  out  32  shared to all slaves.
- ARLEN_S  out  4  shared to all slaves.
- ARSIZE_S  out  3  shared to all slaves.
- ARBURST_S  out  2  shared to all slaves.
- ARVALID_S0/ARVALID_S1/ARVALID_SDEFAULT  out  1  per-slave valid.
- ARREADY_S0/ARREADY_S1/ARREADY_SDEFAULT  in  1  per-slave ready.
- RVALID_Sx, RREADY_Sx, RLAST_Sx (x = 0, 1, DEFAULT)  in  1  read-data monitor taps.
- busy  out  1  transaction in flight.
- grant  out  2  one-hot owning master: bit0 = M0, bit1 = M1.
- beat_err  out  1  one-cycle pulse on burst-length mismatch.

Function
REQ-004 FSM states SHALL be IDLE, ADDR, DATA; one outstanding read system-wide.
REQ-005 IDLE: if any ARVALID_Mx is high, the block SHALL:
- pick a winner round-robin (priority to the master not granted last);
- pulse that master's ARREADY_Mx for exactly that cycle;
- register ID, address, length, size and burst;
- move to ADDR.
REQ-006 ARREADY_Mx SHALL be 0 in ADDR and DATA; only the winner's ARREADY SHALL ever be high.
REQ-007 ADDR: exactly one ARVALID_S* SHALL be high, chosen by decode of the registered address:
- [S0_BASE, S0_BASE+0xFFFF] -> S0;
- [S1_BASE, S1_BASE+0xFFFF] -> S1;
- otherwise -> SDEFAULT.
ADDR SHALL hold while that slave's ARREADY is 0, and move to DATA in the handshake cycle.
REQ-008 ARID_S SHALL be {2'b00, grant[1:0], registered ARID}, so bits [5:4] carry the one-hot master; all AR payload outputs SHALL come only from registers and stay stable from entry to ADDR until the handshake.
REQ-009 DATA: a 5-bit beat counter, cleared on entry, SHALL increment on each RVALID&RREADY of the target slave only; handshakes on other slaves SHALL be ignored.
REQ-010 The transaction SHALL end, returning to IDLE, on a target-slave handshake with RLAST=1.
REQ-011 If RLAST arrives on beat count ≠ registered ARLEN, beat_err SHALL pulse 1 cycle, coincident with the return to IDLE.
REQ-012 If the counter passes ARLEN without RLAST, beat_err SHALL pulse once and the FSM SHALL stay in DATA until RLAST.
REQ-013 last_grant SHALL update at IDLE->ADDR; new requests in the cycle DATA->IDLE SHALL NOT be accepted until the following IDLE cycle (minimum 1 idle cycle between transactions).
REQ-014 busy SHALL be 1 in ADDR and DATA; grant SHALL hold the owner in ADDR/DATA and be 2'b00 in IDLE.
REQ-015 Latency SHALL be: master accept to ARVALID_S* high = 1 cycle.

Reset
REQ-016 While rst=1 (asynchronous), the state SHALL be IDLE and:
- all ARREADY_Mx, ARVALID_S*, busy and beat_err SHALL be 0;
- grant SHALL be 2'b00 and payload registers 0;
- last_grant SHALL be M1, so M0 wins the first tie.
REQ-017 Reset asserted mid-ADDR or mid-DATA SHALL abort with no further pulses; the first cycle after release SHALL be IDLE.

Verification
REQ-018 The bench SHALL cover these scenarios:
- M0 ARADDR=0x0000_0010, ARLEN=3; S0 ready 2 cycles late; 4 beats with RLAST on the 4th -> ARVALID_S0 only, ARID_S=8'h1?, busy 1 to IDLE, beat_err=0.
- M0 and M1 both valid every cycle, single-beat reads -> grants alternate M0,M1,M0,M1.
- M1 ARADDR=0x0002_0000 -> ARVALID_SDEFAULT only, ARID_S[5:4]=2'b10.
- ARLEN=3 but RLAST on beat 2 -> beat_err pulses once, FSM returns to IDLE.
- S1 handshakes during an S0 transaction -> counter unchanged, no completion.
- rst asserted in DATA -> outputs cleared immediately; next M0 request accepted normally.
